// File: rtl/uart_capture_rx.sv
`default_nettype none
// ============================================================================
// uart_capture_rx : UART receiver with parametrised frame format, FWFT FIFO,
//                   valid/ready read port and sticky error flags.
// Revision       : 1.0
// ============================================================================
module uart_capture_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 57600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_rx,
  input  logic                          i_en,
  output logic [DATA_BITS-1:0]          o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_busy,
  output logic                          o_frame_err,
  output logic                          o_parity_err,
  output logic                          o_overflow,
  input  logic                          i_clr_err
);

  localparam int C_DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int C_CW  = $clog2(C_DIV);
  localparam int C_AW  = $clog2(FIFO_DEPTH);
  localparam int C_BW  = 4;
  localparam logic [C_CW-1:0] C_FULL_BIT = C_CW'(C_DIV - 1);
  localparam logic [C_CW-1:0] C_HALF_BIT = C_CW'(C_DIV / 2 - 1);
  localparam logic [C_BW-1:0] C_LAST_DATA = C_BW'(DATA_BITS - 1);
  localparam logic [C_BW-1:0] C_LAST_STOP = C_BW'(STOP_BITS - 1);
  localparam logic [C_AW:0]   C_DEPTH = (C_AW + 1)'(FIFO_DEPTH);

  if (C_DIV < 8) begin : g_div_check
    $error("uart_capture_rx: clock/baud ratio must be at least 8");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_capture_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [C_CW-1:0]        cnt_q, cnt_d;
  logic [C_BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bad_q, par_bad_d;
  logic                   rx_meta_q, rx_meta_d;
  logic                   rx_sync_q, rx_sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [C_AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [C_AW:0]          count_q, count_d;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   overflow_q, overflow_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

  logic                   w_push_req, w_frame_set, w_parity_set;
  logic                   w_pop, w_full, w_do_push, w_overflow_set, w_par_exp;

  // Expected parity bit so that data plus parity has the configured weight.
  assign w_par_exp = (PARITY == 1) ? ~(^shift_q) : (^shift_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    w_push_req   = 1'b0;
    w_frame_set  = 1'b0;
    w_parity_set = 1'b0;
    rx_meta_d    = i_rx;
    rx_sync_d    = rx_meta_q;
    rx_prev_d    = rx_sync_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_en && rx_prev_q && !rx_sync_q) begin
          state_d   = S_START;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == C_HALF_BIT) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == C_FULL_BIT) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == C_LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (cnt_q == C_FULL_BIT) begin
          cnt_d     = '0;
          par_bad_d = (rx_sync_q != w_par_exp);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == C_FULL_BIT) begin
          cnt_d = '0;
          if (!rx_sync_q) begin
            w_frame_set = 1'b1;
            state_d     = S_BREAK;
          end else if (bit_cnt_q == C_LAST_STOP) begin
            w_push_req   = 1'b1;
            w_parity_set = par_bad_q;
            state_d      = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A push at full is accepted only when a pop frees a slot on the same edge.
  always_comb begin
    w_pop          = (count_q != '0) && i_ready;
    w_full         = (count_q == C_DEPTH);
    w_do_push      = w_push_req && (!w_full || w_pop);
    w_overflow_set = w_push_req && w_full && !w_pop;
    wr_ptr_d       = w_do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d       = w_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d        = count_q;
    if (w_do_push && !w_pop)      count_d = count_q + 1'b1;
    else if (!w_do_push && w_pop) count_d = count_q - 1'b1;
    frame_err_d  = (frame_err_q  && !i_clr_err) || w_frame_set;
    parity_err_d = (parity_err_q && !i_clr_err) || w_parity_set;
    overflow_d   = (overflow_q   && !i_clr_err) || w_overflow_set;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign o_valid      = (count_q != '0);
  assign o_data       = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_count      = count_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_err  = frame_err_q;
  assign o_parity_err = parity_err_q;
  assign o_overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_capture_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_capture_rx : directed tests of uart_capture_rx in four configurations.
// Revision           : 1.0
// ============================================================================
module tb_uart_capture_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // a: defaults (DIV 868); p: even parity; s: 8N1 depth 4; m: 7O2. p/s/m use DIV 16.
  logic       rx_a = 1'b1, en_a = 1'b1, ready_a = 1'b1, clr_a = 1'b0;
  logic [7:0] data_a;
  logic [4:0] count_a;
  logic       valid_a, busy_a, fe_a, pe_a, ov_a;

  logic       rx_p = 1'b1, en_p = 1'b1, ready_p = 1'b1, clr_p = 1'b0;
  logic [7:0] data_p;
  logic [4:0] count_p;
  logic       valid_p, busy_p, fe_p, pe_p, ov_p;

  logic       rx_s = 1'b1, en_s = 1'b1, ready_s = 1'b1, clr_s = 1'b0;
  logic [7:0] data_s;
  logic [2:0] count_s;
  logic       valid_s, busy_s, fe_s, pe_s, ov_s;

  logic       rx_m = 1'b1, en_m = 1'b1, ready_m = 1'b0, clr_m = 1'b0;
  logic [6:0] data_m;
  logic [4:0] count_m;
  logic       valid_m, busy_m, fe_m, pe_m, ov_m;

  uart_capture_rx u_a (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_a), .i_en(en_a), .o_data(data_a), .o_valid(valid_a),
    .i_ready(ready_a), .o_count(count_a), .o_busy(busy_a), .o_frame_err(fe_a),
    .o_parity_err(pe_a), .o_overflow(ov_a), .i_clr_err(clr_a));

  uart_capture_rx #(.CLK_HZ(1600), .BAUD(100), .PARITY(2)) u_p (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_p), .i_en(en_p), .o_data(data_p), .o_valid(valid_p),
    .i_ready(ready_p), .o_count(count_p), .o_busy(busy_p), .o_frame_err(fe_p),
    .o_parity_err(pe_p), .o_overflow(ov_p), .i_clr_err(clr_p));

  uart_capture_rx #(.CLK_HZ(1600), .BAUD(100), .FIFO_DEPTH(4)) u_s (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_s), .i_en(en_s), .o_data(data_s), .o_valid(valid_s),
    .i_ready(ready_s), .o_count(count_s), .o_busy(busy_s), .o_frame_err(fe_s),
    .o_parity_err(pe_s), .o_overflow(ov_s), .i_clr_err(clr_s));

  uart_capture_rx #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_m (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_m), .i_en(en_m), .o_data(data_m), .o_valid(valid_m),
    .i_ready(ready_m), .o_count(count_m), .o_busy(busy_m), .o_frame_err(fe_m),
    .o_parity_err(pe_m), .o_overflow(ov_m), .i_clr_err(clr_m));

  // Pop recorders: a pop is any negedge where valid && ready hold.
  logic [7:0] q_a[$];
  logic [7:0] q_p[$];
  logic [7:0] q_s[$];
  logic [6:0] q_m[$];
  logic       valid_a_prev = 1'b0;
  longint     t_rise_a = 0;

  always @(negedge clk) begin
    if (valid_a && ready_a) q_a.push_back(data_a);
    if (valid_p && ready_p) q_p.push_back(data_p);
    if (valid_s && ready_s) q_s.push_back(data_s);
    if (valid_m && ready_m) q_m.push_back(data_m);
    if (valid_a && !valid_a_prev && t_rise_a == 0) t_rise_a = longint'($time);
    valid_a_prev = valid_a;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int which, input logic v);
    case (which)
      0: rx_a = v;
      1: rx_p = v;
      2: rx_s = v;
      default: rx_m = v;
    endcase
  endtask

  task automatic send_bits(input int which, input int div, input logic [8:0] d, input int nbits);
    set_rx(which, 1'b0);
    cyc(div);
    for (int i = 0; i < nbits; i++) begin
      set_rx(which, d[i]);
      cyc(div);
    end
  endtask

  task automatic send_frame(input int which, input int div, input logic [8:0] d, input int nbits,
                            input int par_mode, input bit bad_par, input int nstop);
    logic [8:0] mask;
    logic       pb;
    mask = (9'h1 << nbits) - 9'h1;
    send_bits(which, div, d, nbits);
    if (par_mode != 0) begin
      pb = ^(d & mask);
      if (par_mode == 1) pb = ~pb;
      if (bad_par) pb = ~pb;
      set_rx(which, pb);
      cyc(div);
    end
    for (int i = 0; i < nstop; i++) begin
      set_rx(which, 1'b1);
      cyc(div);
    end
    set_rx(which, 1'b1);
    cyc(4);
  endtask

  task automatic test_reset;
    n_cmp++; if ({data_a, valid_a, count_a, busy_a} !== 15'h0) begin n_fail++;
      $display("FAIL reset_outputs: data/valid/count/busy=%h expected 0", {data_a, valid_a, count_a, busy_a}); end
    n_cmp++; if ({fe_a, pe_a, ov_a, fe_s, pe_s, ov_s} !== 6'h0) begin n_fail++;
      $display("FAIL reset_flags: %b expected 000000", {fe_a, pe_a, ov_a, fe_s, pe_s, ov_s}); end
  endtask

  task automatic test_default;
    logic [7:0] exp[4];
    logic [7:0] got;
    longint     t0, lat;
    exp = '{8'h55, 8'hA3, 8'h00, 8'hFF};
    q_a.delete();
    t0 = longint'($time);
    for (int i = 0; i < 4; i++) send_frame(0, 868, {1'b0, exp[i]}, 8, 0, 1'b0, 1);
    cyc(10);
    n_cmp++; if (q_a.size() !== 4) begin n_fail++;
      $display("FAIL default_pops: got %0d pops expected 4", q_a.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q_a.size()) ? q_a[i] : 8'hxx;
      n_cmp++; if (got !== exp[i]) begin n_fail++;
        $display("FAIL default_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
    n_cmp++; if ({fe_a, pe_a, ov_a, count_a} !== 8'h0) begin n_fail++;
      $display("FAIL default_flags: fe/pe/ov/count=%b expected 0", {fe_a, pe_a, ov_a, count_a}); end
    lat = (t_rise_a - t0) / 10 - (9 * 868 + 434);
    n_cmp++; if (lat < 2 || lat > 4) begin n_fail++;
      $display("FAIL default_latency: valid rose %0d cycles after stop mid expected 2..4", lat); end
  endtask

  task automatic test_parity;
    q_p.delete();
    send_frame(1, 16, 9'h07, 8, 2, 1'b1, 1);
    n_cmp++; if (!(q_p.size() == 1 && q_p[0] === 8'h07)) begin n_fail++;
      $display("FAIL parity_bad_data: got %0d pops first %h expected 1 pop 07", q_p.size(),
               (q_p.size() > 0) ? q_p[0] : 8'hxx); end
    n_cmp++; if (pe_p !== 1'b1) begin n_fail++;
      $display("FAIL parity_flag_set: got %b expected 1", pe_p); end
    clr_p = 1'b1; cyc(1); clr_p = 1'b0; cyc(1);
    n_cmp++; if (pe_p !== 1'b0) begin n_fail++;
      $display("FAIL parity_flag_clear: got %b expected 0", pe_p); end
    send_frame(1, 16, 9'h07, 8, 2, 1'b0, 1);
    n_cmp++; if (!(q_p.size() == 2 && q_p[1] === 8'h07 && pe_p === 1'b0 && fe_p === 1'b0)) begin n_fail++;
      $display("FAIL parity_good: pops %0d pe %b fe %b expected 2 pops pe 0 fe 0", q_p.size(), pe_p, fe_p); end
  endtask

  task automatic test_frame_error;
    q_s.delete();
    ready_s = 1'b1;
    send_bits(2, 16, 9'h3C, 8);
    set_rx(2, 1'b0);
    cyc(48);
    n_cmp++; if ({busy_s, fe_s, count_s} !== 5'b11000) begin n_fail++;
      $display("FAIL frame_err_hold: busy/fe/count=%b expected 11000", {busy_s, fe_s, count_s}); end
    set_rx(2, 1'b1);
    cyc(4);
    n_cmp++; if (busy_s !== 1'b0) begin n_fail++;
      $display("FAIL frame_err_release: busy %b expected 0", busy_s); end
    send_frame(2, 16, 9'h81, 8, 0, 1'b0, 1);
    n_cmp++; if (!(q_s.size() == 1 && q_s[0] === 8'h81)) begin n_fail++;
      $display("FAIL frame_err_next: pops %0d first %h expected 1 pop 81", q_s.size(),
               (q_s.size() > 0) ? q_s[0] : 8'hxx); end
    clr_s = 1'b1; cyc(1); clr_s = 1'b0; cyc(1);
  endtask

  task automatic test_glitch;
    q_s.delete();
    set_rx(2, 1'b0); cyc(4); set_rx(2, 1'b1); cyc(4);
    n_cmp++; if (busy_s !== 1'b1) begin n_fail++;
      $display("FAIL glitch_busy: got %b expected 1", busy_s); end
    cyc(6);
    n_cmp++; if ({busy_s, count_s, fe_s, pe_s, ov_s} !== 7'h0 || q_s.size() != 0) begin n_fail++;
      $display("FAIL glitch_idle: busy/count/flags=%b pops %0d expected all 0", {busy_s, count_s, fe_s, pe_s, ov_s}, q_s.size()); end
  endtask

  task automatic test_overflow;
    ready_s = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(2, 16, 9'h10 + 9'(i), 8, 0, 1'b0, 1);
    n_cmp++; if ({count_s, ov_s, valid_s} !== 5'b10011) begin n_fail++;
      $display("FAIL overflow_full: count/ov/valid=%b expected 10011", {count_s, ov_s, valid_s}); end
    q_s.delete();
    ready_s = 1'b1; cyc(6); ready_s = 1'b0; cyc(1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (!(i < q_s.size() && q_s[i] === 8'h10 + 8'(i))) begin n_fail++;
        $display("FAIL overflow_read%0d: got %h expected %h", i, (i < q_s.size()) ? q_s[i] : 8'hxx, 8'h10 + 8'(i)); end
    end
    clr_s = 1'b1; cyc(1); clr_s = 1'b0; cyc(1);
    n_cmp++; if ({ov_s, count_s} !== 4'h0) begin n_fail++;
      $display("FAIL overflow_clear: ov/count=%b expected 0000", {ov_s, count_s}); end
    for (int i = 0; i < 4; i++) send_frame(2, 16, 9'h20 + 9'(i), 8, 0, 1'b0, 1);
    // Pop exactly on the edge that pushes the fifth byte.
    fork
      send_frame(2, 16, 9'h24, 8, 0, 1'b0, 1);
      begin cyc(2 + 8 + 9 * 16); ready_s = 1'b1; cyc(1); ready_s = 1'b0; end
    join
    n_cmp++; if ({count_s, ov_s, data_s} !== {3'd4, 1'b0, 8'h21}) begin n_fail++;
      $display("FAIL push_pop_full: count %0d ov %b head %h expected 4 0 21", count_s, ov_s, data_s); end
  endtask

  task automatic test_7o2_and_reset;
    ready_m = 1'b0;
    send_frame(3, 16, 9'h5A, 7, 1, 1'b0, 2);
    n_cmp++; if ({count_m, data_m, pe_m, fe_m} !== {5'd1, 7'h5A, 2'b00}) begin n_fail++;
      $display("FAIL m_7o2_rx: count %0d data %h pe %b fe %b expected 1 5a 0 0", count_m, data_m, pe_m, fe_m); end
    send_bits(3, 16, 9'h2B, 3);
    cyc(3);
    rst = 1'b1; set_rx(3, 1'b1); cyc(1);
    n_cmp++; if ({count_m, data_m, valid_m, busy_m} !== 14'h0) begin n_fail++;
      $display("FAIL m_reset_during: count/data/valid/busy=%h expected 0", {count_m, data_m, valid_m, busy_m}); end
    cyc(2); rst = 1'b0; cyc(3);
    n_cmp++; if ({count_m, data_m, valid_m, busy_m, fe_m, pe_m, ov_m} !== 17'h0) begin n_fail++;
      $display("FAIL m_reset_after: outputs=%h expected 0", {count_m, data_m, valid_m, busy_m, fe_m, pe_m, ov_m}); end
    q_m.delete();
    ready_m = 1'b1;
    send_frame(3, 16, 9'h15, 7, 1, 1'b0, 2);
    n_cmp++; if (!(q_m.size() == 1 && q_m[0] === 7'h15 && pe_m === 1'b0)) begin n_fail++;
      $display("FAIL m_after_reset_rx: pops %0d first %h pe %b expected 1 pop 15 pe 0", q_m.size(),
               (q_m.size() > 0) ? q_m[0] : 7'hxx, pe_m); end
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(3);
    test_reset();
    test_default();
    test_parity();
    test_frame_error();
    test_glitch();
    test_overflow();
    test_7o2_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_capture_rx.md
Name: uart_capture_rx

Overview:
Parametrised UART receive/capture block for the servant SoC environment. It decodes the SoC serial output `q` into bytes with configurable baud, frame format and buffering. It replaces the fixed-baud, 8N1, print-only decoder with synthesizable logic. The block is usable both in benches and on-board, with a first-word-fall-through (FWFT) FIFO, valid/ready read port and sticky error flags.

Parameters:
- CLK_HZ, 50000000: i_clk frequency in Hz.
- BAUD, 57600: line rate. DIV = (CLK_HZ + BAUD/2) / BAUD; DIV ≥ 8 is required (elaboration error otherwise).
- DATA_BITS, 8: data bits per frame, legal range 5..9, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries, power of two, ≥ 2.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_rx  in  1  serial line, idle high, asynchronous to i_clk.
- i_en  in  1  receiver enable; while low, no new frame starts.
- o_data  out  DATA_BITS  FIFO head.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accept; pop occurs when o_valid && i_ready.
- o_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_busy  out  1  frame in progress (state ≠ IDLE).
- o_frame_err  out  1  sticky: stop bit sampled low.
- o_parity_err  out  1  sticky: parity mismatch.
- o_overflow  out  1  sticky: byte dropped because FIFO full.
- i_clr_err  in  1  synchronous clear of all sticky flags.

Behaviour:
- Reset values: o_data = 0, o_valid = 0, o_count = 0, o_busy = 0, all error flags 0, state IDLE. The 2-flop i_rx synchroniser resets to 1.
- Baud counter counts 0..DIV-1 and is reloaded on every state entry.
- IDLE: a falling edge (synced rx 1→0) with i_en = 1 moves to START.
- START: sample at DIV/2 cycles.
  - rx = 1: glitch; return to IDLE with no push and no flag.
  - rx = 0: go to DATA.
- DATA: sample every DIV cycles into a shift register, LSB first. After DATA_BITS samples, go to PARITY if PARITY ≠ 0, else STOP.
- PARITY: one sample. Mismatch against odd/even parity of the data latches a parity error for this frame.
- STOP: STOP_BITS samples, DIV apart.
  - Any stop sample = 0: set o_frame_err, discard the byte, go to BREAK.
  - All stop samples = 1: push the byte (even if the parity error is set; the parity flag becomes sticky at the same edge), then go to IDLE.
- BREAK: wait until synced rx = 1, then go to IDLE. No start detection occurs in BREAK.
- Push timing: the push happens on the clock edge of the final stop-bit sample. o_valid and o_data reflect the FIFO head on the next cycle (FWFT).
- Push when full without a simultaneous pop: byte dropped, o_overflow set, FIFO contents unchanged.
- Push when full with a simultaneous pop: both take effect, o_count stays at FIFO_DEPTH, no overflow.
- Push when empty: o_valid rises the next cycle. Zero-latency bypass to o_data is not required.
- Pointers wrap modulo FIFO_DEPTH. o_count is exact, 0..FIFO_DEPTH.
- i_clr_err is lower priority than a same-cycle set: if an error event and a clear coincide, the flag ends at 1.
- i_en deasserted mid-frame: the current frame completes normally. Only new starts are blocked.
- i_rst mid-frame: everything returns to reset values immediately. The FIFO is emptied and partial frames are lost.
- Max sampling error is ±1 cycle per bit relative to nominal. The design tolerates ±2% baud mismatch at DIV ≥ 16.

Test Plan:
- Defaults (DIV = 868), send 0x55, 0xA3, 0x00, 0xFF (8N1) with i_ready = 1 → four pops in order, each valid once, all flags 0. o_valid rises 2–4 cycles after the mid-point of the stop bit.
- PARITY = 2, send 0x07 with a wrong parity bit → o_data = 0x07 delivered and o_parity_err = 1. Then i_clr_err → flag 0. Next correct frame 0x07 → no flag.
- Stop bit forced low on 0x3C, line held low for 3 bit times then released → no byte, o_frame_err = 1, o_busy stays high until rx goes high. The next frame 0x81 is received correctly.
- 1/4-bit low glitch on idle line → no push, o_busy returns to 0 at DIV/2 after the edge, no flags.
- FIFO_DEPTH = 4, i_ready = 0, send 5 bytes 0x10..0x14 → o_count = 4, o_overflow = 1, reads return 0x10..0x13. Separately, a push coinciding with a pop at full → count stays 4, no overflow.
- DATA_BITS = 7, STOP_BITS = 2, PARITY = 1, send 0x5A; separately assert i_rst mid-DATA → 0x5A (7-bit) received correctly. After the reset pulse, all outputs are 0, o_count = 0 and the next frame is received correctly.
